// File: rtl/icache.sv
// Direct-mapped read-only instruction cache; hit answers 1 cycle after request, data the cycle after.
// Miss refills words 0..3 over valid/ready (stalls hold beat request); rdy=0 freezes all state.
module icache #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 4,
  parameter int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        valid_to_icache,
  input  logic [31:0] addr_to_icache,
  output logic        next_cycle_ready_from_icache,
  output logic [31:0] data_from_icache,
  output logic        valid_to_mem,
  output logic [31:0] addr_to_mem,
  input  logic        ready_from_mem,
  input  logic [31:0] data_from_mem
);
  localparam int WB    = OFFSET_BITS - 2;
  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = LINES << WB;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL} state_t;

  state_t            state_q, state_d;
  logic [31:2]       req_addr_q, req_addr_d;
  logic [WB-1:0]     cnt_q, cnt_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              mem_vld_q, mem_vld_d;

  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [WORDS];

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic [WB-1:0]         req_word;
  logic                  hit, beat, last_beat;
  logic                  unused_byte_bits;

  assign unused_byte_bits = ^addr_to_icache[1:0];

  assign req_tag   = req_addr_q[31 -: TAG_BITS];
  assign req_idx   = req_addr_q[OFFSET_BITS +: INDEX_BITS];
  assign req_word  = req_addr_q[2 +: WB];
  assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign beat      = (state_q == REFILL) && ready_from_mem;
  assign last_beat = (cnt_q == {WB{1'b1}});

  assign next_cycle_ready_from_icache = (state_q == LOOKUP) && hit;
  assign data_from_icache = data_q;
  assign valid_to_mem     = mem_vld_q;
  assign addr_to_mem      = mem_addr_q;

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    data_d     = data_q;
    mem_addr_d = mem_addr_q;
    mem_vld_d  = mem_vld_q;
    unique case (state_q)
      IDLE: begin
        if (valid_to_icache) begin
          req_addr_d = addr_to_icache[31:2];
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          data_d  = data_mem[{req_idx, req_word}];
          state_d = IDLE;
        end else begin
          cnt_d      = '0;
          mem_vld_d  = 1'b1;
          mem_addr_d = {req_addr_q[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          state_d    = REFILL;
        end
      end
      REFILL: begin
        if (ready_from_mem) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            valid_d[req_idx] = 1'b1;
            mem_vld_d        = 1'b0;
            state_d          = LOOKUP;
          end else begin
            mem_addr_d = mem_addr_q + 32'd4;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      cnt_q      <= '0;
      valid_q    <= '0;
      data_q     <= '0;
      mem_addr_q <= '0;
      mem_vld_q  <= 1'b0;
    end else if (rdy) begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      mem_addr_q <= mem_addr_d;
      mem_vld_q  <= mem_vld_d;
    end
  end

  // Beats land straight in the array; the line only becomes visible when its valid bit sets.
  always_ff @(posedge clk) begin
    if (rdy && beat) begin
      data_mem[{req_idx, cnt_q}] <= data_from_mem;
      if (last_beat) tag_mem[req_idx] <= req_tag;
    end
  end
endmodule

// File: tb/tb_icache.sv
// Directed plus randomized fetches against a line-level cache model and a synthetic memory image.
module tb_icache;
  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        valid_to_icache;
  logic [31:0] addr_to_icache;
  logic        next_cycle_ready_from_icache;
  logic [31:0] data_from_icache;
  logic        valid_to_mem;
  logic [31:0] addr_to_mem;
  logic        ready_from_mem;
  logic [31:0] data_from_mem;

  int vectors = 0;
  int miscompares = 0;

  bit          mvalid [64];
  logic [21:0] mtag   [64];
  logic [31:0] last_data;

  icache dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .valid_to_icache(valid_to_icache), .addr_to_icache(addr_to_icache),
    .next_cycle_ready_from_icache(next_cycle_ready_from_icache),
    .data_from_icache(data_from_icache),
    .valid_to_mem(valid_to_mem), .addr_to_mem(addr_to_mem),
    .ready_from_mem(ready_from_mem), .data_from_mem(data_from_mem)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    if (a < 32'd16) return (w + 32'd1) * 32'h11;
    return (w * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered at a negedge inside REFILL; serves n beats starting at word 'first'.
  task automatic do_beats(input logic [31:0] base, input int first, input int n, input int stall);
    for (int b = first; b < first + n; b++) begin
      for (int s = 0; s < stall; s++) begin
        check("stall_vtm", {31'd0, valid_to_mem}, 32'd1);
        check("stall_addr", addr_to_mem, base + 32'(4 * b));
        check("stall_pulse", {31'd0, next_cycle_ready_from_icache}, 32'd0);
        step();
      end
      check("beat_vtm", {31'd0, valid_to_mem}, 32'd1);
      check("beat_addr", addr_to_mem, base + 32'(4 * b));
      ready_from_mem = 1'b1;
      data_from_mem  = mem_model(base + 32'(4 * b));
      step();
      ready_from_mem = 1'b0;
      data_from_mem  = $urandom;
    end
  endtask

  task automatic fetch(input logic [31:0] a, input int stall);
    logic [31:0] base;
    int          idx;
    logic [21:0] tg;
    bit          hit;
    base = {a[31:4], 4'b0};
    idx  = int'(a[9:4]);
    tg   = a[31:10];
    hit  = mvalid[idx] && (mtag[idx] == tg);
    valid_to_icache = 1'b1;
    addr_to_icache  = a;
    step();
    valid_to_icache = 1'b0;
    addr_to_icache  = $urandom;
    check("lookup_vtm", {31'd0, valid_to_mem}, 32'd0);
    if (!hit) begin
      check("miss_pulse", {31'd0, next_cycle_ready_from_icache}, 32'd0);
      step();
      do_beats(base, 0, 4, stall);
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
      check("after_refill_vtm", {31'd0, valid_to_mem}, 32'd0);
    end else begin
      ready_from_mem = 1'($urandom_range(0, 1));
    end
    check("ready_pulse", {31'd0, next_cycle_ready_from_icache}, 32'd1);
    step();
    ready_from_mem = 1'b0;
    check("fetch_data", data_from_icache, mem_model(a));
    check("pulse_width", {31'd0, next_cycle_ready_from_icache}, 32'd0);
    last_data = mem_model(a);
  endtask

  initial begin
    logic [31:0] ra;
    int          pool_idx [4];
    logic [21:0] pool_tag [4];
    pool_idx = '{0, 1, 2, 63};
    pool_tag = '{22'd0, 22'd1, 22'd2, 22'h3FFFFF};
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    rst = 1'b0; rdy = 1'b1; valid_to_icache = 1'b0; addr_to_icache = '0;
    ready_from_mem = 1'b0; data_from_mem = '0; last_data = '0;
    #12;
    check("rst_pulse", {31'd0, next_cycle_ready_from_icache}, 32'd0);
    check("rst_data", data_from_icache, 32'd0);
    check("rst_vtm", {31'd0, valid_to_mem}, 32'd0);
    check("rst_atm", addr_to_mem, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    fetch(32'h0000_0000, 0);
    check("first_word", data_from_icache, 32'h11);
    fetch(32'h0000_0008, 0);
    check("hit_word2", data_from_icache, 32'h33);
    fetch(32'h0000_000C, 0);
    check("b2b_word3", data_from_icache, 32'h44);
    fetch(32'h0000_0400, 0);
    fetch(32'h0000_0000, 0);
    fetch(32'h0000_1234, 3);

    // Frozen LOOKUP hit: pulse stays visible, output register holds.
    valid_to_icache = 1'b1;
    addr_to_icache  = 32'h0000_1238;
    step();
    valid_to_icache = 1'b0;
    check("frz_pulse0", {31'd0, next_cycle_ready_from_icache}, 32'd1);
    rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("frz_pulse", {31'd0, next_cycle_ready_from_icache}, 32'd1);
      check("frz_data", data_from_icache, last_data);
    end
    rdy = 1'b1;
    step();
    check("unfrz_data", data_from_icache, mem_model(32'h0000_1238));
    check("unfrz_pulse", {31'd0, next_cycle_ready_from_icache}, 32'd0);

    // Reset during beat 2 abandons the refill.
    valid_to_icache = 1'b1;
    addr_to_icache  = 32'h0000_2000;
    step();
    valid_to_icache = 1'b0;
    check("mr_miss", {31'd0, next_cycle_ready_from_icache}, 32'd0);
    step();
    do_beats(32'h0000_2000, 0, 2, 0);
    rst = 1'b0;
    #1;
    check("mr_vtm", {31'd0, valid_to_mem}, 32'd0);
    check("mr_atm", addr_to_mem, 32'd0);
    check("mr_pulse", {31'd0, next_cycle_ready_from_icache}, 32'd0);
    check("mr_data", data_from_icache, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    @(negedge clk);
    fetch(32'h0000_2000, 0);

    for (int n = 0; n < 80; n++) begin
      ra = {pool_tag[$urandom_range(0, 3)], 6'(pool_idx[$urandom_range(0, 3)]),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      fetch(ra, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
